// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of the transmitter's dual-clock FIFO: write address/strobe,
// Gray write pointer export, read-pointer synchronizer, and full/almost-full/fill/overrun.
module fifo_wr_ctrl #(
  parameter int ADDR_BITS = 7,
  parameter int AF_MARGIN = 4
) (
  input  logic                 w_clk,
  input  logic                 n_rst,
  input  logic                 w_enable,
  input  logic                 clear_overrun,
  input  logic [ADDR_BITS:0]   r_count,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic                 w_strobe,
  output logic [ADDR_BITS:0]   w_count,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_BITS:0]   fill,
  output logic                 overrun
);

  localparam int PW = ADDR_BITS + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'((1 << ADDR_BITS) - AF_MARGIN);

  function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin;
  logic [PW-1:0] r_q1;
  logic [PW-1:0] r_sync;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] wnext;
  logic [PW-1:0] gnext;
  logic [PW-1:0] full_match;
  logic [PW-1:0] fill_next;
  logic          accepted;
  logic          rejected;

  assign accepted = w_enable & ~full;
  assign rejected = w_enable & full;
  assign w_strobe = accepted;
  assign w_addr   = wbin[ADDR_BITS-1:0];

  always_comb begin
    r_bin      = gray_to_bin(r_sync);
    wnext      = wbin + {{ADDR_BITS{1'b0}}, accepted};
    gnext      = bin_to_gray(wnext);
    // Gray image of the read pointer advanced by one full lap of the RAM
    full_match = {~r_sync[PW-1:PW-2], r_sync[PW-3:0]};
    fill_next  = wnext - r_bin;
  end

  always_ff @(posedge w_clk) begin
    if (!n_rst) begin
      r_q1   <= '0;
      r_sync <= '0;
    end else begin
      r_q1   <= r_count;
      r_sync <= r_q1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!n_rst) begin
      wbin        <= '0;
      w_count     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      fill        <= '0;
    end else begin
      wbin        <= wnext;
      w_count     <= gnext;
      full        <= (gnext == full_match);
      almost_full <= (fill_next >= AF_LEVEL);
      fill        <= fill_next;
    end
  end

  // A rejected write outranks a simultaneous clear so no overrun is ever lost
  always_ff @(posedge w_clk) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (rejected) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: pointer-arithmetic model plus a write-address scoreboard.
module tb_fifo_wr_ctrl;

  logic       w_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       w_enable = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] r_count = '0;
  logic [6:0] w_addr;
  logic       w_strobe;
  logic [7:0] w_count;
  logic       full;
  logic       almost_full;
  logic [7:0] fill;
  logic       overrun;

  fifo_wr_ctrl #(.ADDR_BITS(7), .AF_MARGIN(4)) dut (
    .w_clk(w_clk), .n_rst(n_rst), .w_enable(w_enable), .clear_overrun(clear_overrun),
    .r_count(r_count), .w_addr(w_addr), .w_strobe(w_strobe), .w_count(w_count),
    .full(full), .almost_full(almost_full), .fill(fill), .overrun(overrun)
  );

  always #5 w_clk = ~w_clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  // model of the write-domain view
  bit m_known = 0;
  int m_w = 0, m_q1 = 0, m_rs = 0, m_fill = 0;
  bit m_full = 0, m_af = 0, m_ovr = 0;

  int strobe_count = 0;
  bit af_seen = 0;
  int af_first_fill = -1;
  bit prev_valid = 0, prev_acc = 0;
  logic [7:0] prev_wc = '0;
  bit wrap_seen = 0, full_seen = 0;
  bit last_strobe = 0;
  int last_addr = -1;

  function automatic logic [7:0] gray8(input int v);
    logic [7:0] b;
    b = v[7:0];
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst_n_v, input bit we, input bit clr, input int rptr);
    bit exp_acc;
    bit new_ovr;
    @(negedge w_clk);
    n_rst = rst_n_v;
    w_enable = we;
    clear_overrun = clr;
    r_count = gray8(rptr);
    #1;
    exp_acc = we && !m_full;
    if (m_known) begin
      checkOutput("w_strobe", w_strobe, exp_acc);
      if (exp_acc) exp_q.push_back(m_w & 127);
      if (w_strobe) begin
        if (exp_q.size() == 0) checkOutput("sb_unexpected_strobe", w_strobe, 0);
        else checkOutput("w_addr", w_addr, exp_q.pop_front());
      end
      checkOutput("w_count", w_count, gray8(m_w));
      checkOutput("full", full, m_full);
      checkOutput("almost_full", almost_full, m_af);
      checkOutput("fill", fill, m_fill);
      checkOutput("overrun", overrun, m_ovr);
      if (prev_valid) checkOutput("gray_step", $countones(prev_wc ^ w_count), prev_acc ? 1 : 0);
    end
    if (w_strobe === 1'b1) strobe_count++;
    last_strobe = (w_strobe === 1'b1);
    last_addr = w_addr;
    if (almost_full === 1'b1 && !af_seen) begin
      af_seen = 1;
      af_first_fill = fill;
    end
    if (prev_valid && prev_wc == 8'h80 && w_count == 8'h00) wrap_seen = 1;
    if (full === 1'b1) full_seen = 1;
    prev_wc = w_count;
    prev_acc = exp_acc;
    prev_valid = rst_n_v && m_known;
    @(posedge w_clk);
    if (!rst_n_v) begin
      m_w = 0; m_q1 = 0; m_rs = 0; m_fill = 0;
      m_full = 0; m_af = 0; m_ovr = 0; m_known = 1;
    end else begin
      new_ovr = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_w = (m_w + (exp_acc ? 1 : 0)) & 255;
      m_fill = (m_w - m_rs + 256) & 255;
      m_full = (m_fill == 128);
      m_af = (m_fill >= 124);
      m_ovr = new_ovr;
      m_rs = m_q1;
      m_q1 = rptr & 255;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hist[$];
    int rp, n0, cyc;

    // fill from empty, then keep pushing into a full FIFO
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    strobe_count = 0;
    for (int i = 0; i < 130; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    #2;
    checkOutput("t1_strobes", strobe_count, 128);
    checkOutput("t1_full", full, 1);
    checkOutput("t1_fill", fill, 128);
    checkOutput("t1_wcount", w_count, 8'hC0);
    checkOutput("t1_af_first", af_first_fill, 124);
    checkOutput("t1_overrun", overrun, 1);

    // read side frees one slot
    applyStimulus(1, 0, 0, 1);
    #2 checkOutput("t2_full_e1", full, 1);
    applyStimulus(1, 0, 0, 1);
    #2 checkOutput("t2_full_e2", full, 1);
    applyStimulus(1, 0, 0, 1);
    #2 checkOutput("t2_full_e3", full, 0);
    checkOutput("t2_fill_e3", fill, 127);
    applyStimulus(1, 1, 0, 1);
    checkOutput("t2_strobe", last_strobe, 1);
    checkOutput("t2_addr", last_addr, 0);

    // overrun set beats clear
    applyStimulus(1, 0, 1, 1);
    #2 checkOutput("t4_cleared", overrun, 0);
    applyStimulus(1, 1, 1, 1);
    #2 checkOutput("t4_set_wins", overrun, 1);
    applyStimulus(1, 0, 1, 1);
    #2 checkOutput("t4_clear", overrun, 0);

    // reset in the middle of a burst
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 50; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    #2;
    checkOutput("t5_wcount", w_count, 0);
    checkOutput("t5_fill", fill, 0);
    checkOutput("t5_full", full, 0);
    checkOutput("t5_af", almost_full, 0);
    checkOutput("t5_overrun", overrun, 0);
    checkOutput("t5_waddr", w_addr, 0);

    // wrap with the read pointer trailing a few cycles behind
    wrap_seen = 0;
    full_seen = 0;
    n0 = strobe_count;
    cyc = 0;
    while ((strobe_count - n0) < 300 && cyc < 600) begin
      hist.push_back(m_w);
      rp = (hist.size() > 4) ? hist.pop_front() : 0;
      applyStimulus(1, 1, 0, rp);
      cyc++;
    end
    checkOutput("t3_writes", strobe_count - n0, 300);
    checkOutput("t3_wrap", wrap_seen, 1);
    checkOutput("t3_full_seen", full_seen, 0);

    // steady state at the almost-full threshold
    rp = m_w;
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, rp);
    for (int i = 0; i < 124; i++) applyStimulus(1, 1, 0, rp);
    applyStimulus(1, 0, 0, rp + 1);
    applyStimulus(1, 0, 0, rp + 2);
    rp = rp + 2;
    for (int i = 0; i < 10; i++) begin
      rp++;
      applyStimulus(1, 1, 0, rp);
      #2;
      checkOutput("t6_fill", fill, 124);
      checkOutput("t6_af", almost_full, 1);
      checkOutput("t6_full", full, 0);
    end
    applyStimulus(1, 0, 0, rp);

    checkOutput("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
